trace_reader: RTL and testbench
===============================

TRACE_READER -- requirements
Module: trace_reader

Interface
REQ-001 Parameter ADDR_W, default 8, SRAM word-address width; trace depth is 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 32, SRAM word width and trace entry width.
REQ-003 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock, shared with the trace SRAM.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to stream a trace.
REQ-007 abort  input  1  synchronous cancel of the current stream.
REQ-008 trace_len  input  ADDR_W+1  number of entries to stream, 0..2^ADDR_W; sampled on an accepted start.
REQ-009 sram_csb  output  1  SRAM chip select, active-low.
REQ-010 sram_web  output  1  SRAM write enable, active-low; tied to 1 (read-only).
REQ-011 sram_addr  output  ADDR_W  SRAM read address.
REQ-012 sram_dout  input  DATA_W  SRAM read data, valid in the cycle after the request cycle.
REQ-013 trace_valid  output  1  trace_data holds a valid entry.
REQ-014 trace_data  output  DATA_W  current trace entry (memory address for the cache model).
REQ-015 trace_ready  input  1  consumer accepts the entry when trace_valid && trace_ready at a clock edge.
REQ-016 busy  output  1  high in states other than IDLE.
REQ-017 done  output  1  one-cycle pulse when all trace_len entries have been accepted.
REQ-018 entry_count  output  ADDR_W+1  number of entries accepted in the current or last stream.

Function
REQ-019 The FSM SHALL have three states: IDLE, FETCH and DRAIN.
REQ-020 IDLE -> FETCH on start with trace_len>0; issue index, entry_count and FIFO are cleared, and trace_len is latched.
REQ-021 start with trace_len==0 in IDLE SHALL pulse done in the next cycle, stay in IDLE, and issue no reads.
REQ-022 start while busy SHALL be ignored.
REQ-023 In FETCH, a read SHALL be issued (sram_csb=0, sram_addr=issue index) in any cycle where (fifo_count + inflight - pop) < 2.
REQ-024 Each issued read increments the issue index, which starts at 0.
REQ-025 sram_csb SHALL be 1 in every cycle with no read issued; sram_addr holds its last value.
REQ-026 Read data SHALL be written into a 2-entry FIFO at the edge ending the cycle after the request.
REQ-027 trace_valid = FIFO non-empty; trace_data = FIFO head.
REQ-028 Latency from the start cycle to the first trace_valid SHALL be 3 cycles.
REQ-029 With trace_ready held high, the block SHALL deliver one entry per cycle.
REQ-030 When the FIFO is full, trace_data SHALL hold stable while trace_ready is low.
REQ-031 FETCH -> DRAIN after the cycle that issues read number trace_len.
REQ-032 DRAIN -> IDLE at the edge where accepted entries reach trace_len; done SHALL be high in the following cycle.
REQ-033 Simultaneous push and pop on a FIFO holding one entry SHALL leave the count unchanged; order is preserved.
REQ-034 entry_count SHALL increment on each accept and hold its value in IDLE until the next accepted start.
REQ-035 trace_len==2^ADDR_W SHALL read addresses 0..2^ADDR_W-1 with no wrap.
REQ-036 abort in any busy state SHALL, at the next edge, go to IDLE, flush the FIFO, and discard in-flight read data.
REQ-037 After abort, done SHALL not pulse, and entry_count holds the number of entries accepted before the abort.
REQ-038 abort and start asserted together SHALL be treated as abort only.

Reset
REQ-039 While reset_n=0: state IDLE, sram_csb=1, sram_web=1, sram_addr=0, trace_valid=0, trace_data=0, busy=0, done=0, entry_count=0, FIFO empty, no read in flight.
REQ-040 Reset asserted mid-stream SHALL take effect immediately; no done pulse follows.

Verification
REQ-041 SRAM model preloaded word i=0x1000+i; start, trace_len=4, ready=1 -> trace_valid from cycle 3; data 0x1000..0x1003 on consecutive cycles; done in the cycle after the last accept; entry_count=4.
REQ-042 trace_len=5, ready toggling 1,0,0,1,... -> at most 2 outstanding entries (FIFO plus in flight); no loss or duplication; data in order 0x1000..0x1004; done once.
REQ-043 start with trace_len=0 -> done pulse next cycle; sram_csb stays 1; busy stays 0.
REQ-044 trace_len=256, ready=1 -> addresses 0..255 each read exactly once; entry_count=256; done pulses once.
REQ-045 abort after 2 accepts of trace_len=8 -> IDLE next cycle; trace_valid=0; entry_count=2; no done; a new start then streams from address 0.
REQ-046 reset_n pulsed low mid-stream -> all outputs return to reset values asynchronously; the next start behaves as in REQ-041.

Source files
------------

// File: rtl/trace_reader.sv
`default_nettype none
// ============================================================================
// Module      : trace_reader
// Description : Streams trace_len words from a synchronous read-only SRAM
//               through a 2-entry FIFO to a valid/ready consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   trace_len,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              trace_valid,
    output logic [DATA_W-1:0] trace_data,
    input  logic              trace_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   entry_count
);

    localparam logic [ADDR_W:0] c_cnt_one = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDR_W:0]     r_len;          // latched stream length
    logic [ADDR_W:0]     r_issue_idx;    // reads issued so far / next address
    logic [ADDR_W:0]     r_entry_count;  // entries accepted by the consumer
    logic                r_inflight;     // a read was issued last cycle
    logic [ADDR_W-1:0]   r_addr;         // last address presented to the SRAM
    logic                r_done;

    logic [DATA_W-1:0]   r_fifo_mem [2];
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [1:0]          r_fifo_count;

    logic                w_issue;
    logic                w_pop;
    logic                w_push;
    logic                w_flush;
    logic                w_start_ok;
    logic                w_zero_done;
    logic                w_last_accept;
    logic [2:0]          w_occ;

    // Handshake and FIFO occupancy seen by the read-issue decision.
    // The occupancy counts the in-flight read so the FIFO can never overflow.
    assign w_pop   = (r_fifo_count != 2'd0) && trace_ready;
    assign w_push  = r_inflight;
    assign w_flush = abort && (r_state != IDLE);
    assign w_occ   = {1'b0, r_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // Next-state decode, read issue and completion detection.
    always_comb begin
        w_state_next  = r_state;
        w_issue       = 1'b0;
        w_start_ok    = 1'b0;
        w_zero_done   = 1'b0;
        w_last_accept = 1'b0;
        case (r_state)
            IDLE: begin
                // Abort takes priority: a simultaneous start is dropped.
                if (start && !abort) begin
                    if (trace_len != '0) begin
                        w_start_ok   = 1'b1;
                        w_state_next = FETCH;
                    end else begin
                        w_zero_done  = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_occ < 3'd2) begin
                    w_issue = 1'b1;
                    if ((r_issue_idx + c_cnt_one) == r_len) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_pop && ((r_entry_count + c_cnt_one) == r_len)) begin
                    w_last_accept = 1'b1;
                    w_state_next  = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Stream bookkeeping: length, issue index, accept counter, done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len         <= '0;
            r_issue_idx   <= '0;
            r_entry_count <= '0;
            r_inflight    <= 1'b0;
            r_addr        <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done     <= w_zero_done | w_last_accept;
            // Read data returning after an abort is simply never pushed.
            r_inflight <= w_issue;
            if (w_start_ok) begin
                r_len         <= trace_len;
                r_issue_idx   <= '0;
                r_entry_count <= '0;
            end else begin
                if (w_issue) begin
                    r_issue_idx <= r_issue_idx + c_cnt_one;
                end
                if (w_pop && (r_state != IDLE)) begin
                    r_entry_count <= r_entry_count + c_cnt_one;
                end
            end
            if (w_issue) begin
                r_addr <= r_issue_idx[ADDR_W-1:0];
            end
        end
    end

    // Two-entry FIFO between the SRAM read port and the consumer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fifo_mem[0] <= '0;
            r_fifo_mem[1] <= '0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_fifo_count  <= 2'd0;
        end else if (w_flush || w_start_ok) begin
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_fifo_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= sram_dout;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + 2'd1;
                2'b01:   r_fifo_count <= r_fifo_count - 2'd1;
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // SRAM port: read-only, chip select only in issue cycles, address held otherwise.
    assign sram_csb    = ~w_issue;
    assign sram_web    = 1'b1;
    assign sram_addr   = w_issue ? r_issue_idx[ADDR_W-1:0] : r_addr;

    assign trace_valid = (r_fifo_count != 2'd0);
    assign trace_data  = r_fifo_mem[r_rd_ptr];
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign entry_count = r_entry_count;

endmodule
`default_nettype wire

// File: tb/tb_trace_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_reader
// Description : Self-checking bench for trace_reader: stream table, random
//               streams against a transaction-level model, directed corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_reader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   trace_len;
    logic              sram_csb;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dout;
    logic              trace_valid;
    logic [DATA_W-1:0] trace_data;
    logic              trace_ready;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   entry_count;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem [DEPTH];

    typedef struct {
        int         len;
        logic [7:0] pat;        // periodic ready pattern, bit = cycle % 8
        bit         rnd;        // random ready instead of pattern
        int         exp_first;  // cycles from start to first trace_valid
        int         exp_count;  // entries expected to be accepted
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    // Synchronous-read SRAM model: data appears the cycle after the request.
    always @(posedge clk) begin
        if (!sram_csb) sram_dout <= mem[sram_addr];
    end

    trace_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .trace_len   (trace_len),
        .sram_csb    (sram_csb),
        .sram_web    (sram_web),
        .sram_addr   (sram_addr),
        .sram_dout   (sram_dout),
        .trace_valid (trace_valid),
        .trace_data  (trace_data),
        .trace_ready (trace_ready),
        .busy        (busy),
        .done        (done),
        .entry_count (entry_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One stream: the model is the ordered list of words 0x1000+i, the set of
    // addresses that must each be read once, and one done after the last accept.
    task automatic run_stream(input int len, input logic [7:0] pat, input bit rnd,
                              input int exp_first, input int exp_count, input string tag);
        int c, acc, last_acc, first_valid, done_cnt, done_cyc;
        int reads_total, reads_bad, max_out, stall_bad, data_bad, budget;
        int rc[DEPTH];
        logic [DATA_W-1:0] exp_q[$];
        logic pv, pr;
        logic [DATA_W-1:0] pd;
        for (int i = 0; i < DEPTH; i++) rc[i] = 0;
        for (int i = 0; i < len; i++) exp_q.push_back(32'h1000 + i);
        c = 0; acc = 0; last_acc = -10; first_valid = -1; done_cnt = 0; done_cyc = -1;
        reads_total = 0; reads_bad = 0; max_out = 0; stall_bad = 0; data_bad = 0;
        pv = 1'b0; pr = 1'b0; pd = '0;
        budget = 4 * len + 40;
        @(posedge clk); #1;
        start       = 1'b1;
        trace_len   = len[ADDR_W:0];
        trace_ready = rnd ? 1'($urandom_range(0, 1)) : pat[0];
        while (c < budget) begin
            @(negedge clk);
            if (trace_valid && first_valid < 0) first_valid = c;
            if (pv && !pr && (!trace_valid || trace_data !== pd)) stall_bad++;
            if (reads_total - acc > max_out) max_out = reads_total - acc;
            if (!sram_csb) begin
                reads_total++;
                if (int'(sram_addr) < len) rc[sram_addr]++;
                else reads_bad++;
            end
            if (trace_valid && trace_ready) begin
                if (exp_q.size() == 0) data_bad++;
                else begin
                    if (trace_data !== exp_q[0]) data_bad++;
                    void'(exp_q.pop_front());
                end
                acc++;
                last_acc = c;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            pv = trace_valid; pr = trace_ready; pd = trace_data;
            if (acc == len && c > last_acc + 2) break;
            @(posedge clk); #1;
            start = 1'b0;
            c++;
            trace_ready = rnd ? 1'($urandom_range(0, 1)) : pat[c % 8];
        end
        for (int i = 0; i < len; i++) if (rc[i] != 1) reads_bad++;
        check({tag, " first_valid"}, first_valid, exp_first);
        check({tag, " accepted"},    acc, exp_count);
        check({tag, " data_order"},  data_bad, 0);
        check({tag, " reads_once"},  reads_bad, 0);
        check({tag, " outstanding"}, (max_out <= 2) ? 1 : 0, 1);
        check({tag, " stall_hold"},  stall_bad, 0);
        check({tag, " done_count"},  done_cnt, 1);
        check({tag, " done_cycle"},  done_cyc, last_acc + 1);
        check({tag, " entry_count"}, entry_count, exp_count);
        check({tag, " busy_after"},  busy, 0);
        trace_ready = 1'b0;
    endtask

    initial begin
        int n, acc, dseen, rseen, bseen, dcyc;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000 + i;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; trace_len = '0; trace_ready = 1'b0;

        // Reset state
        #2;
        check("rst busy",        busy, 0);
        check("rst valid",       trace_valid, 0);
        check("rst csb",         sram_csb, 1);
        check("rst web",         sram_web, 1);
        check("rst addr",        sram_addr, 0);
        check("rst data",        trace_data, 0);
        check("rst done",        done, 0);
        check("rst entry_count", entry_count, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Stream table
        vecs[0] = '{4,   8'hFF,       1'b0, 3, 4};
        vecs[1] = '{5,   8'b10011001, 1'b0, 3, 5};
        vecs[2] = '{1,   8'hFF,       1'b0, 3, 1};
        vecs[3] = '{2,   8'b01010101, 1'b0, 3, 2};
        vecs[4] = '{9,   8'b00001111, 1'b0, 3, 9};
        vecs[5] = '{256, 8'hFF,       1'b0, 3, 256};
        vecs[6] = '{7,   8'h00,       1'b1, 3, 7};
        vecs[7] = '{3,   8'b11100000, 1'b0, 3, 3};
        for (int v = 0; v < 8; v++) begin
            run_stream(vecs[v].len, vecs[v].pat, vecs[v].rnd,
                       vecs[v].exp_first, vecs[v].exp_count, $sformatf("vec%0d", v));
        end

        // Random lengths with random back-pressure
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 40);
            run_stream(n, 8'h00, 1'b1, 3, n, $sformatf("rnd%0d", r));
        end

        // Zero-length start: done next cycle, no reads, never busy
        @(posedge clk); #1;
        start = 1'b1; trace_len = '0;
        dseen = 0; rseen = 0; bseen = 0; dcyc = -1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) begin dseen++; dcyc = c; end
            if (!sram_csb) rseen++;
            if (busy) bseen++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("zero done_count", dseen, 1);
        check("zero done_cycle", dcyc, 1);
        check("zero reads",      rseen, 0);
        check("zero busy",       bseen, 0);

        // Abort after two accepts of an 8-entry stream
        @(posedge clk); #1;
        start = 1'b1; trace_len = 9'd8; trace_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        acc = 0; dseen = 0; n = 0;
        while (acc < 2 && n < 50) begin
            @(negedge clk);
            if (trace_valid && trace_ready) acc++;
            if (done) dseen++;
            @(posedge clk); #1;
            n++;
        end
        check("abort reached_2", acc, 2);
        trace_ready = 1'b0; abort = 1'b1;
        @(negedge clk);
        check("abort busy_before", busy, 1);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort busy",        busy, 0);
        check("abort valid",       trace_valid, 0);
        check("abort entry_count", entry_count, 2);
        for (int c = 0; c < 4; c++) begin
            if (done) dseen++;
            @(negedge clk);
        end
        check("abort no_done", dseen, 0);
        run_stream(4, 8'hFF, 1'b0, 3, 4, "post_abort");

        // Abort together with start in IDLE is abort only
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; trace_len = 9'd6;
        dseen = 0; rseen = 0; bseen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) dseen++;
            if (!sram_csb) rseen++;
            if (busy) bseen++;
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0;
        end
        check("abort_start busy",  bseen, 0);
        check("abort_start reads", rseen, 0);
        check("abort_start done",  dseen, 0);
        check("abort_start entry_count", entry_count, 4);

        // Asynchronous reset mid-stream
        @(posedge clk); #1;
        start = 1'b1; trace_len = 9'd8; trace_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst busy",        busy, 0);
        check("mid_rst valid",       trace_valid, 0);
        check("mid_rst csb",         sram_csb, 1);
        check("mid_rst addr",        sram_addr, 0);
        check("mid_rst data",        trace_data, 0);
        check("mid_rst done",        done, 0);
        check("mid_rst entry_count", entry_count, 0);
        @(posedge clk); #1;
        reset_n = 1'b1; trace_ready = 1'b0;
        dseen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) dseen++;
        end
        check("mid_rst no_done", dseen, 0);
        run_stream(4, 8'hFF, 1'b0, 3, 4, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
